// File: rtl/cfg_master.sv
// Configuration bus initiator: command FIFO, one-at-a-time bus FSM with timeout, response handshake.
// Optional read-modify-write support is built when CFG_MASTER_RMW_EN is defined.
module cfg_master #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic        c_clk,
  input  logic        c_rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [1:0]  cmd_size,
`ifdef CFG_MASTER_RMW_EN
  input  logic        cmd_rmw,
  input  logic [31:0] cmd_mask,
`endif
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        c_valid,
  input  logic        c_ready,
  output logic        c_write,
  output logic [31:0] c_addr,
  output logic [31:0] c_wdata,
  output logic [1:0]  c_size,
  input  logic [31:0] c_rdata
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // the offering side holds valid and payload stable until that edge.

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    RESP
`ifdef CFG_MASTER_RMW_EN
    ,
    RD,
    GAP,
    WR
`endif
  } state_t;

  state_t state;

  logic          f_write [DEPTH];
  logic [31:0]   f_addr  [DEPTH];
  logic [31:0]   f_wdata [DEPTH];
  logic [1:0]    f_size  [DEPTH];
`ifdef CFG_MASTER_RMW_EN
  logic          f_rmw   [DEPTH];
  logic [31:0]   f_mask  [DEPTH];
  logic [31:0]   wdata_q;
  logic [31:0]   mask_q;
  logic [31:0]   rd_q;
`endif

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [7:0]    timer;
  logic          push;
  logic          pop;
  logic          bus_phase;

  // cmd_ready depends only on the registered count, so a pop never frees space in the same cycle.
  assign cmd_ready = ~c_rst & (count != CW'(DEPTH));
  assign push      = cmd_valid & cmd_ready;
  assign pop       = (state == IDLE) && (count != '0);

  always_comb begin
    bus_phase = (state == REQ);
`ifdef CFG_MASTER_RMW_EN
    bus_phase = bus_phase | (state == RD) | (state == WR);
`endif
  end

  always_ff @(posedge c_clk) begin
    if (push) begin
      f_write[wr_ptr] <= cmd_write;
      f_addr[wr_ptr]  <= cmd_addr;
      f_wdata[wr_ptr] <= cmd_wdata;
      f_size[wr_ptr]  <= cmd_size;
`ifdef CFG_MASTER_RMW_EN
      f_rmw[wr_ptr]   <= cmd_rmw;
      f_mask[wr_ptr]  <= cmd_mask;
`endif
    end
  end

  always_ff @(posedge c_clk or posedge c_rst) begin
    if (c_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge c_clk or posedge c_rst) begin
    if (c_rst) begin
      state     <= IDLE;
      timer     <= '0;
      c_valid   <= 1'b0;
      c_write   <= 1'b0;
      c_addr    <= '0;
      c_wdata   <= '0;
      c_size    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
`ifdef CFG_MASTER_RMW_EN
      wdata_q   <= '0;
      mask_q    <= '0;
      rd_q      <= '0;
`endif
    end else begin
      // Timeout is shared by every bus phase; an ack in the same cycle takes priority.
      if (bus_phase && c_valid && !c_ready) begin
        if (timer == 8'(TIMEOUT)) begin
          c_valid   <= 1'b0;
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b1;
          rsp_rdata <= '0;
          state     <= RESP;
        end else begin
          timer <= timer + 8'd1;
        end
      end

      case (state)
        IDLE: begin
          if (pop) begin
            c_write <= f_write[rd_ptr];
            c_addr  <= f_addr[rd_ptr];
            c_wdata <= f_wdata[rd_ptr];
            c_size  <= f_size[rd_ptr];
            state   <= REQ;
`ifdef CFG_MASTER_RMW_EN
            if (f_rmw[rd_ptr]) begin
              c_write <= 1'b0;
              wdata_q <= f_wdata[rd_ptr];
              mask_q  <= f_mask[rd_ptr];
              state   <= RD;
            end
`endif
          end
        end
        REQ: begin
          if (!c_valid) begin
            c_valid <= 1'b1;
            timer   <= '0;
          end else if (c_ready) begin
            c_valid   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= c_write ? 32'd0 : c_rdata;
            state     <= RESP;
          end
        end
`ifdef CFG_MASTER_RMW_EN
        RD: begin
          if (!c_valid) begin
            c_valid <= 1'b1;
            timer   <= '0;
          end else if (c_ready) begin
            c_valid <= 1'b0;
            rd_q    <= c_rdata;
            c_wdata <= (c_rdata & ~mask_q) | (wdata_q & mask_q);
            state   <= GAP;
          end
        end
        GAP: begin
          c_valid <= 1'b1;
          c_write <= 1'b1;
          timer   <= '0;
          state   <= WR;
        end
        WR: begin
          if (c_ready) begin
            c_valid   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= rd_q;
            state     <= RESP;
          end
        end
`endif
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
